uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter OVS, default 16, SHALL set the number of pls_rx ticks per bit period; it SHALL be even and at least 4.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 rx_in  input  1  asynchronous serial line; idle is high.
REQ-005 pls_rx  input  1  one-clk oversampling tick from the baud generator, at OVS x baud rate.
REQ-006 ucfg_rx  input  struct uart_config_rx  static frame configuration, with fields: data_bits (5..8), parity_en, parity_odd, stop2.
REQ-007 en_rxcnt  output  1  enables the baud generator rx tick counter.
REQ-008 rx_data  output  8  received word, right-aligned, with unused MSBs zero.
REQ-009 rx_valid  output  1  rx_data and the error flags hold a word.
REQ-010 rx_ready  input  1  consumer accepts the word.
REQ-011 frame_err, parity_err  output  1 each  status of the held word; valid while rx_valid is high.
REQ-012 overrun  output  1  one-clk pulse when a completed frame is discarded.

Function
REQ-013 rx_in SHALL pass through a 2-FF synchronizer reset to 1; every reference to the line below means the synchronized value rx_s.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP; en_rxcnt SHALL be 1 in every state except IDLE.
REQ-015 IDLE: a falling edge of rx_s (previous sample 1, current sample 0) SHALL move the FSM to START and clear tick_cnt; a line held low SHALL NOT retrigger.
REQ-016 tick_cnt SHALL increment only on pls_rx and SHALL be held when pls_rx is 0.
REQ-017 START: on the tick where tick_cnt==OVS/2-1, the FSM SHALL go to DATA with tick_cnt cleared if rx_s is 0; otherwise it SHALL go to IDLE with no output (glitch rejection).
REQ-018 DATA: on the tick where tick_cnt==OVS-1, the FSM SHALL sample rx_s LSB-first into the shift register, clear tick_cnt, and increment bit_cnt.
REQ-019 After data_bits samples the FSM SHALL go to PARITY if parity_en is 1, otherwise to STOP.
REQ-020 PARITY: the sampled bit SHALL be compared against the XOR of the data bits (even parity), inverted when parity_odd is 1; a mismatch SHALL set the pending parity_err.
REQ-021 STOP: each stop bit SHALL be sampled at tick_cnt==OVS-1; any 0 sample SHALL set the pending frame_err.
- stop2=1 SHALL sample two stop bits.
- After the final stop sample the FSM SHALL complete the frame and go to IDLE in the same clk.
REQ-022 Completion with rx_valid==0, or with rx_valid&&rx_ready in that same clk, SHALL load rx_data and the flags and set rx_valid=1 on the next clk.
REQ-023 Completion with rx_valid&&!rx_ready SHALL discard the new frame, keep the held word unchanged, and pulse overrun for one clk.
REQ-024 rx_valid SHALL clear on rx_valid&&rx_ready when no completion occurs in the same clk.
REQ-025 Latency from the final stop sample tick to rx_valid SHALL be exactly 1 clk.
REQ-026 A config change while the FSM is not in IDLE is unsupported; behaviour in that case SHALL only be required to recover in IDLE.

Reset
REQ-027 rstn low SHALL asynchronously force: state IDLE, synchronizer stages 1, tick_cnt 0, bit_cnt 0, shift register 0, rx_data 0, rx_valid 0, frame_err 0, parity_err 0, overrun 0, en_rxcnt 0.
REQ-028 A reset asserted mid-frame SHALL abandon the frame; after release the FSM SHALL require a fresh falling edge to start.

Structure
REQ-029 The uart_config_rx struct, the OVS default and the FSM state enum SHALL live in the shared uart_config package, alongside uart_config_bdgen.
REQ-030 The synchronizer SHALL be a separate sub-module, uart_sync2, with a reset value parameter.

Verification
REQ-031 8N1, OVS=16, frame 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid for 1 clk, both error flags 0, rx_valid exactly 1 clk after the stop sample.
REQ-032 7O1, frame 0x35 with wrong parity bit -> rx_data=0x35 and parity_err=1; repeated with correct parity bit -> parity_err=0.
REQ-033 8N2, second stop bit driven 0 -> frame_err=1, rx_data still delivered; following 0x3C frame received cleanly.
REQ-034 Low pulse of 5 ticks on idle line -> no rx_valid, FSM back in IDLE, en_rxcnt low.
REQ-035 rx_ready=0, frames 0x11 then 0x22 -> rx_valid holds 0x11, overrun pulses once at completion of 0x22; after rx_ready=1 no further word appears.
REQ-036 rstn asserted during DATA bit 3 -> all outputs at reset values immediately; next frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_config_pkg.sv
// Shared UART configuration types: receiver/baud-generator config structs,
// oversampling default and receiver FSM state encoding.
package uart_config;

    localparam int OVS_DEFAULT = 16;

    typedef struct packed {
        logic [3:0] data_bits;   // 5..8
        logic       parity_en;
        logic       parity_odd;
        logic       stop2;
    } uart_config_rx;

    typedef struct packed {
        logic [15:0] baud_div;
        logic [7:0]  ovs_div;
    } uart_config_bdgen;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start/data/parity/stop FSM with a one-word
// holding register, valid/ready handshake and overrun reporting.
module uart_rx_core
    import uart_config::*;
#(
    parameter int OVS = OVS_DEFAULT
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rx_in,
    input  logic          pls_rx,
    input  uart_config_rx ucfg_rx,
    output logic          en_rxcnt,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic          frame_err,
    output logic          parity_err,
    output logic          overrun
);

    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVS - 1);

    logic rx_s;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rx_in),
        .q    (rx_s)
    );

    rx_state_t     state_reg, state_next;
    logic [TW-1:0] tick_reg, tick_next;
    logic [3:0]    bit_reg, bit_next;
    logic [7:0]    shreg_reg, shreg_next;
    logic          stop_reg, stop_next;
    logic          pe_reg, pe_next;
    logic          fe_reg, fe_next;
    logic          rx_prev_reg;
    logic          complete;
    logic          load;

    logic [7:0]    rx_data_reg;
    logic          rx_valid_reg;
    logic          frame_err_reg;
    logic          parity_err_reg;
    logic          overrun_reg;

    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        bit_next   = bit_reg;
        shreg_next = shreg_reg;
        stop_next  = stop_reg;
        pe_next    = pe_reg;
        fe_next    = fe_reg;
        complete   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rx_prev_reg && !rx_s) begin
                    state_next = START;
                    tick_next  = '0;
                end
            end
            START: begin
                if (pls_rx) begin
                    if (tick_reg == HALF_LAST) begin
                        // Line must still be low at mid start bit, else it was a glitch
                        if (!rx_s) begin
                            state_next = DATA;
                            tick_next  = '0;
                            bit_next   = '0;
                            shreg_next = '0;
                            stop_next  = 1'b0;
                            pe_next    = 1'b0;
                            fe_next    = 1'b0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (pls_rx) begin
                    if (tick_reg == BIT_LAST) begin
                        shreg_next[bit_reg[2:0]] = rx_s;
                        tick_next = '0;
                        bit_next  = bit_reg + 4'd1;
                        if (bit_reg == ucfg_rx.data_bits - 4'd1) begin
                            state_next = ucfg_rx.parity_en ? PARITY : STOP;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (pls_rx) begin
                    if (tick_reg == BIT_LAST) begin
                        pe_next    = rx_s != ((^shreg_reg) ^ ucfg_rx.parity_odd);
                        tick_next  = '0;
                        state_next = STOP;
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (pls_rx) begin
                    if (tick_reg == BIT_LAST) begin
                        tick_next = '0;
                        if (!rx_s) begin
                            fe_next = 1'b1;
                        end
                        if (ucfg_rx.stop2 && !stop_reg) begin
                            stop_next = 1'b1;
                        end else begin
                            complete   = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            tick_reg    <= '0;
            bit_reg     <= '0;
            shreg_reg   <= '0;
            stop_reg    <= 1'b0;
            pe_reg      <= 1'b0;
            fe_reg      <= 1'b0;
            rx_prev_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            bit_reg     <= bit_next;
            shreg_reg   <= shreg_next;
            stop_reg    <= stop_next;
            pe_reg      <= pe_next;
            fe_reg      <= fe_next;
            rx_prev_reg <= rx_s;
        end
    end

    // A completed frame is only accepted when the holding register is free
    // or is being emptied in this very cycle.
    assign load = complete && (!rx_valid_reg || rx_ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            overrun_reg <= complete && rx_valid_reg && !rx_ready;
            if (load) begin
                rx_data_reg    <= shreg_next;
                frame_err_reg  <= fe_next;
                parity_err_reg <= pe_next;
                rx_valid_reg   <= 1'b1;
            end else if (rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign en_rxcnt   = (state_reg != IDLE);
    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: OVS=16, one pls_rx tick every 4 clk.
module tb_uart_rx_core;
    import uart_config::*;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = 16 * TICK_DIV;

    logic          clk;
    logic          rstn;
    logic          rx_in;
    logic          pls_rx;
    uart_config_rx cfg;
    logic          en_rxcnt;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;

    int errors = 0;
    int checks = 0;

    // Observations gathered by the monitor
    int   vcnt = 0;
    int   vcycles = 0;
    int   ovr_cnt = 0;
    int   lat_bad = 0;
    logic prev_valid = 1'b0;
    logic prev_pls = 1'b0;
    logic prev_en = 1'b0;

    int v0, c0, o0;

    uart_rx_core #(
        .OVS (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_in      (rx_in),
        .pls_rx     (pls_rx),
        .ucfg_rx    (cfg),
        .en_rxcnt   (en_rxcnt),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        int pc;
        pc = 0;
        pls_rx = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pc = (pc + 1) % TICK_DIV;
            pls_rx = (pc == 0);
        end
    end

    // A new word must appear one clk after a tick edge that ended the frame
    always @(negedge clk) begin
        if (rx_valid) vcycles++;
        if (rx_valid && !prev_valid) begin
            vcnt++;
            if (!(prev_pls && prev_en && !en_rxcnt)) lat_bad++;
        end
        if (overrun) ovr_cnt++;
        prev_valid = rx_valid;
        prev_pls   = pls_rx;
        prev_en    = en_rxcnt;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_in = bits[i];
            idle(BIT_CLK);
        end
    endtask

    task automatic snap();
        v0 = vcnt;
        c0 = vcycles;
        o0 = ovr_cnt;
    endtask

    initial begin
        rstn     = 1'b0;
        rx_in    = 1'b1;
        rx_ready = 1'b1;
        cfg      = '{data_bits: 4'd8, parity_en: 1'b0, parity_odd: 1'b0, stop2: 1'b0};
        idle(5);
        chk("rst_valid", 32'(rx_valid), 32'h0);
        chk("rst_data", 32'(rx_data), 32'h0);
        chk("rst_en", 32'(en_rxcnt), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        rstn = 1'b1;
        idle(20);

        // 8N1 0xA5
        snap();
        send_bits({6'h3F, 1'b1, 8'hA5, 1'b0}, 10);
        idle(16);
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_fe", 32'(frame_err), 32'h0);
        chk("a5_pe", 32'(parity_err), 32'h0);
        chk("a5_words", 32'(vcnt - v0), 32'd1);
        chk("a5_vcycles", 32'(vcycles - c0), 32'd1);
        chk("a5_latency", 32'(lat_bad), 32'd0);

        // 7O1 0x35: four ones, so odd parity bit is 1
        cfg = '{data_bits: 4'd7, parity_en: 1'b1, parity_odd: 1'b1, stop2: 1'b0};
        idle(4);
        send_bits({6'h3F, 1'b1, 1'b0, 7'h35, 1'b0}, 10);
        idle(16);
        chk("7o1_bad_data", 32'(rx_data), 32'h35);
        chk("7o1_bad_pe", 32'(parity_err), 32'h1);
        send_bits({6'h3F, 1'b1, 1'b1, 7'h35, 1'b0}, 10);
        idle(16);
        chk("7o1_ok_data", 32'(rx_data), 32'h35);
        chk("7o1_ok_pe", 32'(parity_err), 32'h0);
        chk("7o1_ok_fe", 32'(frame_err), 32'h0);

        // 8N2 with second stop bit low, then clean 0x3C
        cfg = '{data_bits: 4'd8, parity_en: 1'b0, parity_odd: 1'b0, stop2: 1'b1};
        idle(4);
        snap();
        send_bits({5'h1F, 1'b0, 1'b1, 8'hC3, 1'b0}, 11);
        rx_in = 1'b1;
        idle(BIT_CLK);
        chk("8n2_bad_data", 32'(rx_data), 32'hC3);
        chk("8n2_bad_fe", 32'(frame_err), 32'h1);
        send_bits({5'h1F, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        idle(16);
        chk("8n2_ok_data", 32'(rx_data), 32'h3C);
        chk("8n2_ok_fe", 32'(frame_err), 32'h0);
        chk("8n2_words", 32'(vcnt - v0), 32'd2);

        // Glitch: 5 ticks low
        cfg = '{data_bits: 4'd8, parity_en: 1'b0, parity_odd: 1'b0, stop2: 1'b0};
        idle(4);
        snap();
        rx_in = 1'b0;
        idle(5 * TICK_DIV);
        rx_in = 1'b1;
        idle(BIT_CLK);
        chk("glitch_words", 32'(vcnt - v0), 32'd0);
        chk("glitch_en", 32'(en_rxcnt), 32'h0);

        // Overrun: consumer stalled over two frames
        rx_ready = 1'b0;
        snap();
        send_bits({6'h3F, 1'b1, 8'h11, 1'b0}, 10);
        send_bits({6'h3F, 1'b1, 8'h22, 1'b0}, 10);
        idle(16);
        chk("ovr_valid", 32'(rx_valid), 32'h1);
        chk("ovr_data", 32'(rx_data), 32'h11);
        chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        rx_ready = 1'b1;
        idle(BIT_CLK);
        chk("ovr_drained", 32'(rx_valid), 32'h0);
        chk("ovr_words", 32'(vcnt - v0), 32'd1);

        // Reset in the middle of data bit 3, then 0x5A
        rx_in = 1'b0;
        idle(BIT_CLK);
        rx_in = 1'b1;
        idle(BIT_CLK);
        rx_in = 1'b0;
        idle(BIT_CLK);
        rx_in = 1'b1;
        idle(BIT_CLK);
        rx_in = 1'b0;
        idle(BIT_CLK / 2);
        chk("mid_en", 32'(en_rxcnt), 32'h1);
        rstn = 1'b0;
        #1;
        chk("mrst_en", 32'(en_rxcnt), 32'h0);
        chk("mrst_data", 32'(rx_data), 32'h0);
        chk("mrst_valid", 32'(rx_valid), 32'h0);
        chk("mrst_flags", 32'({frame_err, parity_err, overrun}), 32'h0);
        idle(3);
        rx_in = 1'b1;
        idle(3);
        rstn = 1'b1;
        idle(BIT_CLK);
        snap();
        send_bits({6'h3F, 1'b1, 8'h5A, 1'b0}, 10);
        idle(16);
        chk("5a_data", 32'(rx_data), 32'h5A);
        chk("5a_flags", 32'({frame_err, parity_err}), 32'h0);
        chk("5a_words", 32'(vcnt - v0), 32'd1);
        chk("final_latency", 32'(lat_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
